// File: rtl/ms_interval_timer.sv
// rtl/ms_interval_timer.sv - millisecond interval sequencer driving an external 1 ms tick counter
module ms_interval_timer #(
  parameter int WIDTH       = 16,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             tick,
  input  logic             clear_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] period_ms,
  input  logic             ms_reached,
  output logic             ms_run,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ms_elapsed
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_RELOAD = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam bit AutoReload = (AUTO_RELOAD != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] elapsed_q, elapsed_d;
  logic             run_q, run_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] elapsed_inc;

  // elapsed_q is always below period_q in RUN, so the increment never wraps
  assign elapsed_inc = elapsed_q + WIDTH'(1);

  always_ff @(posedge tick or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      elapsed_q <= '0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      elapsed_q <= elapsed_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    elapsed_d = elapsed_q;
    run_d     = run_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          period_d  = period_ms;
          elapsed_d = '0;
          busy_d    = 1'b1;
          if (period_ms == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            run_d   = 1'b1;
          end
        end
      end

      S_RUN: begin
        // A millisecond landing on the same edge as stop is deliberately dropped
        if (stop) begin
          state_d = S_IDLE;
          run_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (ms_reached) begin
          elapsed_d = elapsed_inc;
          run_d     = 1'b0;
          state_d   = (elapsed_inc == period_q) ? S_DONE : S_RELOAD;
        end
      end

      S_RELOAD: begin
        if (stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_RUN;
          run_d   = 1'b1;
        end
      end

      S_DONE: begin
        done_d = 1'b1;
        if (stop || !AutoReload) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          elapsed_d = '0;
          state_d   = (period_q == '0) ? S_DONE : S_RELOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
        run_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ms_run     = run_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ms_elapsed = elapsed_q;

endmodule

// File: tb/tb_ms_interval_timer.sv
// tb/tb_ms_interval_timer.sv - scoreboard bench for ms_interval_timer (one-shot and auto-reload)
module tb_ms_interval_timer;

  logic        tick = 1'b0;
  logic        clear_n = 1'b0;
  logic        force_reached = 1'b0;

  logic        start0 = 1'b0, stop0 = 1'b0;
  logic [15:0] period0 = '0;
  logic        reached0, ms_run0, busy0, done0;
  logic [15:0] ms_elapsed0;

  logic        start1 = 1'b0, stop1 = 1'b0;
  logic [15:0] period1 = '0;
  logic        reached1, ms_run1, busy1, done1;
  logic [15:0] ms_elapsed1;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_el0[$], exp_gap0[$], exp_done0[$];
  logic [31:0] exp_el1[$], exp_done1[$];

  always #5 tick = ~tick;

  ms_interval_timer #(.WIDTH(16), .AUTO_RELOAD(0)) dut0 (
    .tick(tick), .clear_n(clear_n), .start(start0), .stop(stop0),
    .period_ms(period0), .ms_reached(reached0), .ms_run(ms_run0),
    .busy(busy0), .done(done0), .ms_elapsed(ms_elapsed0)
  );

  ms_interval_timer #(.WIDTH(16), .AUTO_RELOAD(1)) dut1 (
    .tick(tick), .clear_n(clear_n), .start(start1), .stop(stop1),
    .period_ms(period1), .ms_reached(reached1), .ms_run(ms_run1),
    .busy(busy1), .done(done1), .ms_elapsed(ms_elapsed1)
  );

  // 1 ms counter models: reached after 10 cycles of run, cleared while run is low
  logic [3:0] cnt0 = '0, cnt1 = '0;
  always @(posedge tick) begin
    if (!ms_run0) cnt0 <= '0;
    else if (cnt0 != 4'd9) cnt0 <= cnt0 + 4'd1;
    if (!ms_run1) cnt1 <= '0;
    else if (cnt1 != 4'd9) cnt1 <= cnt1 + 4'd1;
  end
  assign reached0 = (ms_run0 && cnt0 == 4'd9) || force_reached;
  assign reached1 = (ms_run1 && cnt1 == 4'd9) || force_reached;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic pop_check(input string name, inout logic [31:0] q[$], input logic [31:0] act);
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: unexpected output %0d with empty scoreboard", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  int done0_count = 0, done1_count = 0;

  // Monitor: pops expectations whenever the DUTs present a new observable event
  initial begin
    logic [15:0] prev_el0, prev_el1;
    int low0;
    prev_el0 = '0;
    prev_el1 = '0;
    low0 = 0;
    forever begin
      @(negedge tick);
      if (ms_elapsed0 != prev_el0) begin
        pop_check("elapsed0", exp_el0, 32'(ms_elapsed0));
        prev_el0 = ms_elapsed0;
      end
      if (ms_elapsed1 != prev_el1) begin
        pop_check("elapsed1", exp_el1, 32'(ms_elapsed1));
        prev_el1 = ms_elapsed1;
      end
      if (done0) begin
        done0_count++;
        pop_check("done0_elapsed", exp_done0, 32'(ms_elapsed0));
      end
      if (done1) begin
        done1_count++;
        pop_check("done1_elapsed", exp_done1, 32'(ms_elapsed1));
      end
      if (busy0 && !ms_run0) begin
        low0++;
      end else if (busy0 && ms_run0) begin
        if (low0 != 0) pop_check("run_low_gap0", exp_gap0, 32'(low0));
        low0 = 0;
      end else begin
        low0 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset with start and reached asserted
    start0 = 1'b1;
    start1 = 1'b1;
    force_reached = 1'b1;
    #12;
    check("rst_run0", 32'(ms_run0), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_done0", 32'(done0), 0);
    check("rst_elapsed0", 32'(ms_elapsed0), 0);
    check("rst_busy1", 32'(busy1), 0);
    @(negedge tick);
    start0 = 1'b0;
    start1 = 1'b0;
    force_reached = 1'b0;
    @(negedge tick);
    clear_n = 1'b1;
    repeat (3) @(negedge tick);
    check("post_rst_busy0", 32'(busy0), 0);
    check("post_rst_run0", 32'(ms_run0), 0);

    // Basic period of 3 ms
    period0 = 16'd3;
    exp_el0.push_back(1); exp_el0.push_back(2); exp_el0.push_back(3);
    exp_gap0.push_back(1); exp_gap0.push_back(1);
    exp_done0.push_back(3);
    d0 = done0_count;
    start0 = 1'b1;
    @(negedge tick);
    start0 = 1'b0;
    for (int i = 0; i < 300 && !done0; i++) @(negedge tick);
    check("basic_done_seen", 32'(done0), 1);
    check("basic_busy_at_done", 32'(busy0), 0);
    repeat (4) @(negedge tick);
    check("basic_done_once", 32'(done0_count - d0), 1);
    check("basic_busy_after", 32'(busy0), 0);
    check("basic_elapsed_hold", 32'(ms_elapsed0), 3);

    // Zero period
    period0 = 16'd0;
    exp_el0.push_back(0);
    exp_done0.push_back(0);
    start0 = 1'b1;
    @(negedge tick);
    start0 = 1'b0;
    check("zero_done_edge1", 32'(done0), 0);
    check("zero_busy_edge1", 32'(busy0), 1);
    check("zero_run_edge1", 32'(ms_run0), 0);
    @(negedge tick);
    check("zero_done_edge2", 32'(done0), 1);
    check("zero_run_edge2", 32'(ms_run0), 0);
    @(negedge tick);
    check("zero_done_edge3", 32'(done0), 0);
    check("zero_busy_edge3", 32'(busy0), 0);
    check("zero_elapsed", 32'(ms_elapsed0), 0);

    // Stop coinciding with the 2nd reached, period 5
    period0 = 16'd5;
    exp_el0.push_back(1);
    exp_gap0.push_back(1);
    d0 = done0_count;
    start0 = 1'b1;
    @(negedge tick);
    start0 = 1'b0;
    for (int i = 0; i < 300 && !(ms_elapsed0 == 16'd1 && reached0); i++) @(negedge tick);
    check("stop_reached2_seen", 32'(reached0), 1);
    stop0 = 1'b1;
    @(negedge tick);
    stop0 = 1'b0;
    repeat (3) @(negedge tick);
    check("stop_elapsed", 32'(ms_elapsed0), 1);
    check("stop_busy", 32'(busy0), 0);
    check("stop_run", 32'(ms_run0), 0);
    check("stop_no_done", 32'(done0_count - d0), 0);

    // start and stop together in IDLE
    start0 = 1'b1;
    stop0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge tick);
      check("startstop_busy", 32'(busy0), 0);
      check("startstop_run", 32'(ms_run0), 0);
    end
    start0 = 1'b0;
    stop0 = 1'b0;

    // Auto-reload, period 2, period change mid-run ignored
    period1 = 16'd2;
    for (int k = 0; k < 2; k++) begin
      exp_el1.push_back(1); exp_el1.push_back(2); exp_el1.push_back(0);
      exp_done1.push_back(0);
    end
    start1 = 1'b1;
    @(negedge tick);
    start1 = 1'b0;
    for (int i = 0; i < 300 && !done1; i++) @(negedge tick);
    check("auto_done1_seen", 32'(done1), 1);
    check("auto_busy_at_done", 32'(busy1), 1);
    period1 = 16'd4;
    @(negedge tick);
    for (int i = 0; i < 300 && !done1; i++) @(negedge tick);
    check("auto_done2_seen", 32'(done1), 1);
    stop1 = 1'b1;
    @(negedge tick);
    stop1 = 1'b0;
    repeat (3) @(negedge tick);
    check("auto_stop_busy", 32'(busy1), 0);
    check("auto_stop_elapsed", 32'(ms_elapsed1), 0);
    check("auto_done_count", 32'(done1_count), 2);

    // Asynchronous reset mid-RUN with ms_elapsed=2
    period0 = 16'd5;
    exp_el0.push_back(0); exp_el0.push_back(1); exp_el0.push_back(2);
    exp_gap0.push_back(1); exp_gap0.push_back(1);
    start0 = 1'b1;
    @(negedge tick);
    start0 = 1'b0;
    for (int i = 0; i < 300 && !(ms_elapsed0 == 16'd2 && ms_run0); i++) @(negedge tick);
    check("midrst_elapsed_before", 32'(ms_elapsed0), 2);
    exp_el0.push_back(0);
    #2;
    clear_n = 1'b0;
    #1;
    check("midrst_run", 32'(ms_run0), 0);
    check("midrst_busy", 32'(busy0), 0);
    check("midrst_done", 32'(done0), 0);
    check("midrst_elapsed", 32'(ms_elapsed0), 0);
    @(negedge tick);
    clear_n = 1'b1;
    repeat (3) @(negedge tick);
    check("midrst_idle_busy", 32'(busy0), 0);

    check("sb_el0_empty", 32'(exp_el0.size()), 0);
    check("sb_gap0_empty", 32'(exp_gap0.size()), 0);
    check("sb_done0_empty", 32'(exp_done0.size()), 0);
    check("sb_el1_empty", 32'(exp_el1.size()), 0);
    check("sb_done1_empty", 32'(exp_done1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
